// File: rtl/br_issue_sched_if.sv
// Dispatch, CDB snoop and issue-stage signals of the branch issue scheduler.
// The dispatcher/arbiter side uses master; the scheduler itself uses slave.
interface br_issue_sched_if #(
  parameter int unsigned TAG_W = 4
);
  logic             disp_valid;
  logic             disp_ready;
  logic [6:0]       disp_opcode;
  logic [2:0]       disp_funct3;
  logic [31:0]      disp_pc;
  logic [31:0]      disp_imm;
  logic [TAG_W-1:0] disp_rob_tag;
  logic             disp_rs1_rdy;
  logic             disp_rs2_rdy;
  logic [31:0]      disp_rs1_val;
  logic [31:0]      disp_rs2_val;
  logic [TAG_W-1:0] disp_rs1_tag;
  logic [TAG_W-1:0] disp_rs2_tag;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  logic             iss_valid;
  logic [6:0]       iss_opcode;
  logic [2:0]       iss_funct3;
  logic [31:0]      iss_a;
  logic [31:0]      iss_b;
  logic [31:0]      iss_pc;
  logic [31:0]      iss_imm;
  logic [TAG_W-1:0] iss_tag;
  logic             iss_grant;

  modport master (
    output disp_valid, disp_opcode, disp_funct3, disp_pc, disp_imm, disp_rob_tag,
           disp_rs1_rdy, disp_rs2_rdy, disp_rs1_val, disp_rs2_val, disp_rs1_tag, disp_rs2_tag,
           cdb_valid, cdb_tag, cdb_value, iss_grant,
    input  disp_ready, iss_valid, iss_opcode, iss_funct3, iss_a, iss_b, iss_pc, iss_imm, iss_tag
  );

  modport slave (
    input  disp_valid, disp_opcode, disp_funct3, disp_pc, disp_imm, disp_rob_tag,
           disp_rs1_rdy, disp_rs2_rdy, disp_rs1_val, disp_rs2_val, disp_rs1_tag, disp_rs2_tag,
           cdb_valid, cdb_tag, cdb_value, iss_grant,
    output disp_ready, iss_valid, iss_opcode, iss_funct3, iss_a, iss_b, iss_pc, iss_imm, iss_tag
  );
endinterface

// File: rtl/br_issue_sched.sv
// Branch/jump issue scheduler: collapsing age-ordered queue with CDB wakeup,
// feeding a registered issue stage that holds until the CDB slot is granted.
module br_issue_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  br_issue_sched_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] rob_tag;
    logic             rs1_rdy;
    logic [31:0]      rs1_val;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs2_rdy;
    logic [31:0]      rs2_val;
    logic [TAG_W-1:0] rs2_tag;
  } ent_t;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
  } iss_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  ent_t             woke  [DEPTH];
  ent_t             new_ent;
  ent_t             sel_ent;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] sel_idx, wr_idx;
  logic             any_elig, iss_free, do_issue, do_disp, disp_ready_c;
  logic             iss_valid_q, iss_valid_d;
  iss_t             iss_q, iss_d;

  // Capture a broadcast value into any waiting source whose tag matches.
  function automatic ent_t wake(input ent_t e, input logic v,
                                input logic [TAG_W-1:0] t, input logic [31:0] val);
    ent_t r;
    r = e;
    if (v && !e.rs1_rdy && e.rs1_tag == t) begin
      r.rs1_rdy = 1'b1;
      r.rs1_val = val;
    end
    if (v && !e.rs2_rdy && e.rs2_tag == t) begin
      r.rs2_rdy = 1'b1;
      r.rs2_val = val;
    end
    return r;
  endfunction

  assign disp_ready_c   = (count_q < CNT_W'(DEPTH)) & ~flush;
  assign bus.disp_ready = disp_ready_c;
  assign bus.iss_valid  = iss_valid_q;
  assign bus.iss_opcode = iss_q.opcode;
  assign bus.iss_funct3 = iss_q.funct3;
  assign bus.iss_a      = iss_q.a;
  assign bus.iss_b      = iss_q.b;
  assign bus.iss_pc     = iss_q.pc;
  assign bus.iss_imm    = iss_q.imm;
  assign bus.iss_tag    = iss_q.tag;
  assign occupancy      = count_q;

  always_comb begin
    ent_d       = ent_q;
    woke        = ent_q;
    count_d     = count_q;
    iss_valid_d = iss_valid_q;
    iss_d       = iss_q;
    sel_idx     = '0;
    sel_ent     = ent_q[0];
    any_elig    = 1'b0;

    // Oldest entry whose operands were both ready at the start of the cycle.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CNT_W'(i) < count_q && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        any_elig = 1'b1;
        sel_idx  = CNT_W'(i);
        sel_ent  = ent_q[i];
      end
    end

    iss_free = ~iss_valid_q | bus.iss_grant;
    do_issue = iss_free & any_elig;
    do_disp  = bus.disp_valid & disp_ready_c;
    wr_idx   = count_q - CNT_W'(do_issue);

    new_ent.opcode  = bus.disp_opcode;
    new_ent.funct3  = bus.disp_funct3;
    new_ent.pc      = bus.disp_pc;
    new_ent.imm     = bus.disp_imm;
    new_ent.rob_tag = bus.disp_rob_tag;
    new_ent.rs1_rdy = bus.disp_rs1_rdy;
    new_ent.rs1_val = bus.disp_rs1_val;
    new_ent.rs1_tag = bus.disp_rs1_tag;
    new_ent.rs2_rdy = bus.disp_rs2_rdy;
    new_ent.rs2_val = bus.disp_rs2_val;
    new_ent.rs2_tag = bus.disp_rs2_tag;
    new_ent = wake(new_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = wake(ent_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end

    // Collapse above the issued slot, then drop the new entry at the tail.
    for (int i = 0; i < DEPTH; i++) begin
      int unsigned src;
      src = (do_issue && CNT_W'(i) >= sel_idx && (i + 1) < DEPTH) ? i + 1 : i;
      ent_d[i] = woke[src];
      if (do_disp && CNT_W'(i) == wr_idx) ent_d[i] = new_ent;
    end

    count_d = count_q - CNT_W'(do_issue) + CNT_W'(do_disp);

    if (do_issue) begin
      iss_valid_d  = 1'b1;
      iss_d.opcode = sel_ent.opcode;
      iss_d.funct3 = sel_ent.funct3;
      iss_d.a      = sel_ent.rs1_val;
      iss_d.b      = sel_ent.rs2_val;
      iss_d.pc     = sel_ent.pc;
      iss_d.imm    = sel_ent.imm;
      iss_d.tag    = sel_ent.rob_tag;
    end else if (iss_free) begin
      iss_valid_d = 1'b0;
    end

    if (flush) begin
      ent_d       = ent_q;
      count_d     = '0;
      iss_valid_d = 1'b0;
      iss_d       = iss_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end
endmodule
